fp16_afpm_link_driver: RTL

Host-side master for the byte-serial FP16 multiplier link. The block accepts a pair of 16-bit FP16 operands over a valid/ready request port and serializes them onto the two 8-bit operand lanes, low byte first. It then waits a fixed number of cycles and reassembles the 16-bit product from the 8-bit result lane, returning it over a valid/ready response port. It sits between the on-chip test/control logic and the multiplier core's `ui_in`/`uio_in`/`uo_out` pins.

---
 rtl/fp16_afpm_link_driver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fp16_afpm_link_driver.sv
// rtl/fp16_afpm_link_driver.sv - byte-serial host driver for the FP16 multiplier link
// Serializes two FP16 operands onto 8-bit lanes and reassembles the 16-bit product.
module fp16_afpm_link_driver #(
    parameter int unsigned SYNC_CYCLES = 1,
    parameter int unsigned RESP_DELAY  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        link_ena,
    output logic [7:0]  link_a,
    output logic [7:0]  link_b,
    input  logic [7:0]  link_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic [7:0]  txn_count
);

    typedef enum logic [2:0] {
        IDLE, SYNC, SEND_LO, SEND_HI, WAIT, RECV_LO, RECV_HI, RESP
    } state_t;

    localparam logic [3:0] SYNC_LOAD = 4'(SYNC_CYCLES - 1);
    localparam logic [3:0] WAIT_LOAD = 4'(RESP_DELAY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] res_q, res_d;
    logic [7:0]  txn_q, txn_d;
    logic        ready_q, ready_d;
    logic        accept;

    // Ready is registered, so a fresh IDLE spends one cycle before it advertises ready.
    assign accept  = (state_q == IDLE) && ready_q && req_valid;
    assign ready_d = (state_q == IDLE) && !accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            res_q   <= 16'd0;
            txn_q   <= 8'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            txn_q   <= txn_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        txn_d   = txn_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    cnt_d   = SYNC_LOAD;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (cnt_q == 4'd0) state_d = SEND_LO;
                else               cnt_d   = cnt_q - 4'd1;
            end
            SEND_LO: state_d = SEND_HI;
            SEND_HI: begin
                if (RESP_DELAY == 0) begin
                    state_d = RECV_LO;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RECV_LO;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RECV_LO: begin
                res_d[7:0] = link_res;
                state_d    = RECV_HI;
            end
            RECV_HI: begin
                res_d[15:8] = link_res;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    txn_d   = txn_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lanes carry operand bytes only in the two SEND states; zero everywhere else.
    always_comb begin
        link_ena = 1'b0;
        link_a   = 8'd0;
        link_b   = 8'd0;
        case (state_q)
            SYNC, WAIT, RECV_LO, RECV_HI: link_ena = 1'b1;
            SEND_LO: begin
                link_ena = 1'b1;
                link_a   = a_q[7:0];
                link_b   = b_q[7:0];
            end
            SEND_HI: begin
                link_ena = 1'b1;
                link_a   = a_q[15:8];
                link_b   = b_q[15:8];
            end
            default: ;
        endcase
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = res_q;
    assign busy      = (state_q != IDLE);
    assign txn_count = txn_q;

endmodule
